// File: rtl/modclass_pkg.sv
// Shared definitions for the feature fetch sequencer and the modulation classifier.
package modclass_pkg;

  localparam int FEATS_PER_FRAME = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } fetch_state_t;

  // Word order of a frame in BRAM and slot tag carried with each read
  localparam logic [1:0] SLOT_AP = 2'd0;
  localparam logic [1:0] SLOT_AF = 2'd1;
  localparam logic [1:0] SLOT_DP = 2'd2;

  typedef enum logic [2:0] {
    MOD_UNKNOWN = 3'b000,
    MOD_AM      = 3'b001,
    MOD_FM      = 3'b010,
    MOD_PSK     = 3'b011,
    MOD_ASK     = 3'b100,
    MOD_FSK     = 3'b101
  } mod_type_t;

endpackage

// File: rtl/feat_rd_tag_pipe.sv
// BRAM_LAT-deep delay line carrying a valid bit and slot tag alongside each BRAM read,
// so the tag emerges in the same cycle as the read data.
module feat_rd_tag_pipe #(
  parameter int BRAM_LAT = 1,
  parameter int SLOT_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [SLOT_W-1:0] in_slot,
  output logic              out_valid,
  output logic [SLOT_W-1:0] out_slot
);

  logic [BRAM_LAT-1:0]             valid_q;
  logic [BRAM_LAT-1:0][SLOT_W-1:0] slot_q;

  generate
    if (BRAM_LAT == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= '0;
          slot_q  <= '0;
        end else begin
          valid_q[0] <= in_valid;
          slot_q[0]  <= in_slot;
        end
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= '0;
          slot_q  <= '0;
        end else begin
          valid_q <= {valid_q[BRAM_LAT-2:0], in_valid};
          slot_q  <= {slot_q[BRAM_LAT-2:0], in_slot};
        end
      end
    end
  endgenerate

  assign out_valid = valid_q[BRAM_LAT-1];
  assign out_slot  = slot_q[BRAM_LAT-1];

endmodule

// File: rtl/feature_fetch_ctrl.sv
// Walks a contiguous frame table in BRAM (three words per frame) and presents each
// feature triplet on a valid/ready handshake; the BRAM port is used read-only.
module feature_fetch_ctrl
  import modclass_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int BRAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_frames,
  output logic              busy,
  output logic              done,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              feat_valid,
  input  logic              feat_ready,
  output logic [DATA_W-1:0] sigma_ap,
  output logic [DATA_W-1:0] sigma_af,
  output logic [DATA_W-1:0] sigma_dp,
  output logic [15:0]       frame_idx,
  output fetch_state_t      fsm_state
);

  // Handshake: a triplet transfers on any cycle where feat_valid and feat_ready are both 1;
  // feat_valid never drops and the triplet never changes until that transfer.

  fetch_state_t      state_q, state_d;
  logic [1:0]        slot_q;
  logic [15:0]       frame_q, nframes_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] ap_q, af_q, dp_q;
  logic              tag_valid;
  logic [1:0]        tag_slot;
  logic              last_frame;

  assign last_frame = (frame_q == nframes_q - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    done       = 1'b0;
    bram_en    = 1'b0;
    bram_addr  = '0;
    feat_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (num_frames == 16'd0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        busy      = 1'b1;
        bram_en   = 1'b1;
        bram_addr = addr_q;
        if (slot_q == SLOT_DP) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (tag_valid && tag_slot == SLOT_DP) state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        busy       = 1'b1;
        feat_valid = 1'b1;
        if (feat_ready) state_d = last_frame ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // addr_q advances once per issued read, so after a frame it already points at the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q    <= '0;
      frame_q   <= '0;
      nframes_q <= '0;
      addr_q    <= '0;
      ap_q      <= '0;
      af_q      <= '0;
      dp_q      <= '0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        nframes_q <= num_frames;
        addr_q    <= base_addr;
        frame_q   <= '0;
        slot_q    <= SLOT_AP;
      end
      if (state_q == ST_ISSUE) begin
        addr_q <= addr_q + 1'b1;
        slot_q <= (slot_q == SLOT_DP) ? SLOT_AP : slot_q + 2'd1;
      end
      if (state_q == ST_PRESENT && feat_ready && !last_frame) frame_q <= frame_q + 16'd1;
      if (tag_valid) begin
        case (tag_slot)
          SLOT_AP: ap_q <= bram_dout;
          SLOT_AF: af_q <= bram_dout;
          SLOT_DP: dp_q <= bram_dout;
          default: ;
        endcase
      end
    end
  end

  feat_rd_tag_pipe #(.BRAM_LAT(BRAM_LAT), .SLOT_W(2)) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bram_en),
    .in_slot  (slot_q),
    .out_valid(tag_valid),
    .out_slot (tag_slot)
  );

  assign sigma_ap  = ap_q;
  assign sigma_af  = af_q;
  assign sigma_dp  = dp_q;
  assign frame_idx = frame_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_feature_fetch_ctrl.sv
// Self-checking bench: one DUT at BRAM_LAT=1, one at BRAM_LAT=2, sharing a bench-side BRAM model.
module tb_feature_fetch_ctrl;
  import modclass_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT 1 (BRAM_LAT=1) ----------------
  logic        start1 = 0, busy1, done1, en1, valid1, ready1 = 0;
  logic [15:0] base1 = 0, nf1 = 0, addr1, idx1;
  logic [31:0] dout1 = 0, ap1, af1, dp1;
  fetch_state_t st1;

  feature_fetch_ctrl #(.ADDR_W(16), .DATA_W(32), .BRAM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .base_addr(base1), .num_frames(nf1),
    .busy(busy1), .done(done1), .bram_en(en1), .bram_addr(addr1), .bram_dout(dout1),
    .feat_valid(valid1), .feat_ready(ready1), .sigma_ap(ap1), .sigma_af(af1),
    .sigma_dp(dp1), .frame_idx(idx1), .fsm_state(st1)
  );

  // ---------------- DUT 2 (BRAM_LAT=2) ----------------
  logic        start2 = 0, busy2, done2, en2, valid2, ready2 = 0;
  logic [15:0] base2 = 0, nf2 = 0, addr2, idx2;
  logic [31:0] dout2 = 0, pipe2 = 0, ap2, af2, dp2;
  fetch_state_t st2;

  feature_fetch_ctrl #(.ADDR_W(16), .DATA_W(32), .BRAM_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .base_addr(base2), .num_frames(nf2),
    .busy(busy2), .done(done2), .bram_en(en2), .bram_addr(addr2), .bram_dout(dout2),
    .feat_valid(valid2), .feat_ready(ready2), .sigma_ap(ap2), .sigma_af(af2),
    .sigma_dp(dp2), .frame_idx(idx2), .fsm_state(st2)
  );

  // ---------------- BRAM model ----------------
  logic [31:0] mem [0:65535];
  always @(posedge clk) if (en1) dout1 <= mem[addr1];
  always @(posedge clk) begin
    if (en2) pipe2 <= mem[addr2];
    dout2 <= pipe2;
  end

  // ---------------- scoreboard ----------------
  logic [111:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic push_frames(input logic [15:0] b, input logic [15:0] n);
    logic [15:0] a;
    for (int f = 0; f < int'(n); f++) begin
      a = b + 16'(3 * f);
      exp_q.push_back({16'(f), mem[a], mem[a + 16'd1], mem[a + 16'd2]});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_start1(input logic [15:0] b, input logic [15:0] n);
    @(negedge clk);
    start1 = 1'b1; base1 = b; nf1 = n;
    push_frames(b, n);
  endtask

  task automatic drive_start2(input logic [15:0] b, input logic [15:0] n);
    @(negedge clk);
    start2 = 1'b1; base2 = b; nf2 = n;
    push_frames(b, n);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({busy1, done1, en1, addr1, valid1, ap1, af1, dp1, idx1} !== '0 || st1 !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_dut1: got busy=%b done=%b en=%b addr=%h valid=%b ap=%h af=%h dp=%h idx=%0d st=%0d want all 0",
               busy1, done1, en1, addr1, valid1, ap1, af1, dp1, idx1, st1);
    end
    n_vec++;
    if ({busy2, done2, en2, addr2, valid2, ap2, af2, dp2, idx2} !== '0 || st2 !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_dut2: got busy=%b done=%b en=%b valid=%b st=%0d want all 0",
               busy2, done2, en2, valid2, st2);
    end
  endtask

  task automatic test_basic();
    int v1 = -1, v2 = -1, done_c = -1, reads = 0;
    logic [111:0] e, g;
    mem[0] = 80; mem[1] = 120; mem[2] = 150; mem[3] = 5; mem[4] = 10; mem[5] = 400;
    ready1 = 1'b1;
    drive_start1(16'h0000, 16'd2);
    for (int cyc = 1; cyc <= 30 && done_c < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start1 = 1'b0; base1 = 16'($urandom); nf1 = 16'($urandom);
        n_vec++;
        if (busy1 !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy1); end
      end
      if (en1) reads++;
      if (valid1 && ready1) begin
        if (v1 < 0) v1 = cyc; else v2 = cyc;
        g = {idx1, ap1, af1, dp1};
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL basic_triplet: got %h want none", g); end
        else begin
          e = exp_q.pop_front();
          if (g !== e) begin n_err++; $display("FAIL basic_triplet: got %h want %h", g, e); end
        end
      end
      if (done1) begin
        done_c = cyc;
        n_vec++;
        if (busy1 !== 1'b0) begin n_err++; $display("FAIL basic_done_busy: got %b want 0", busy1); end
      end
    end
    n_vec++;
    if (v1 != 5 || v2 != 10 || done_c != 11) begin
      n_err++; $display("FAIL basic_timing: got valid %0d,%0d done %0d want 5,10 done 11", v1, v2, done_c);
    end
    n_vec++;
    if (reads != 6) begin n_err++; $display("FAIL basic_reads: got %0d want 6", reads); end
  endtask

  task automatic test_backpressure();
    int v1 = -1, v2 = -1, done_c = -1, reads = 0;
    logic [111:0] e, g;
    ready1 = 1'b0;
    drive_start1(16'h0100, 16'd2);
    for (int cyc = 1; cyc <= 40 && done_c < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start1 = 1'b0;
      ready1 = (cyc >= 12);
      if (en1) reads++;
      g = {idx1, ap1, af1, dp1};
      if (cyc >= 5 && cyc <= 11) begin
        n_vec++;
        if (exp_q.size() == 0 || {valid1, en1, g} !== {1'b1, 1'b0, exp_q[0]}) begin
          n_err++;
          $display("FAIL stall_hold c%0d: got valid=%b en=%b trip=%h want valid=1 en=0 trip=%h",
                   cyc, valid1, en1, g, (exp_q.size() != 0) ? exp_q[0] : 112'h0);
        end
      end
      if (valid1 && ready1) begin
        if (v1 < 0) v1 = cyc; else v2 = cyc;
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL stall_triplet: got %h want none", g); end
        else begin
          e = exp_q.pop_front();
          if (g !== e) begin n_err++; $display("FAIL stall_triplet: got %h want %h", g, e); end
        end
      end
      if (done1) done_c = cyc;
    end
    n_vec++;
    if (v1 != 12 || v2 != 17 || done_c != 18 || reads != 6) begin
      n_err++;
      $display("FAIL stall_timing: got hs %0d,%0d done %0d reads %0d want 12,17 done 18 reads 6",
               v1, v2, done_c, reads);
    end
  endtask

  task automatic test_zero_frames();
    int done_c = -1, done_n = 0, busy_n = 0, reads = 0;
    ready1 = 1'b1;
    drive_start1(16'($urandom), 16'd0);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start1 = 1'b0;
      if (en1) reads++;
      if (busy1) busy_n++;
      if (done1) begin done_n++; if (done_c < 0) done_c = cyc; end
    end
    n_vec++;
    if (done_c != 1 || done_n != 1 || busy_n != 0 || reads != 0 || st1 !== ST_IDLE) begin
      n_err++;
      $display("FAIL zero_frames: got done@%0d x%0d busy %0d reads %0d st %0d want done@1 x1 busy 0 reads 0 st 0",
               done_c, done_n, busy_n, reads, st1);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] addr_log[$];
    logic [15:0] want_addr [3];
    logic [111:0] e, g;
    int done_c = -1;
    want_addr[0] = 16'hFFFE; want_addr[1] = 16'hFFFF; want_addr[2] = 16'h0000;
    ready1 = 1'b1;
    drive_start1(16'hFFFE, 16'd1);
    for (int cyc = 1; cyc <= 20 && done_c < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start1 = 1'b0;
      if (en1) addr_log.push_back(addr1);
      if (valid1 && ready1) begin
        g = {idx1, ap1, af1, dp1};
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL wrap_triplet: got %h want none", g); end
        else begin
          e = exp_q.pop_front();
          if (g !== e) begin n_err++; $display("FAIL wrap_triplet: got %h want %h", g, e); end
        end
      end
      if (done1) done_c = cyc;
    end
    n_vec++;
    if (addr_log.size() != 3) begin
      n_err++; $display("FAIL wrap_count: got %0d reads want 3", addr_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (addr_log[i] !== want_addr[i]) begin
          n_err++; $display("FAIL wrap_addr%0d: got %h want %h", i, addr_log[i], want_addr[i]);
        end
      end
    end
    n_vec++;
    if (done_c != 6) begin n_err++; $display("FAIL wrap_done: got %0d want 6", done_c); end
  endtask

  task automatic test_lat2();
    int v1 = -1, v2 = -1, done_c = -1, reads = 0;
    logic [111:0] e, g;
    ready2 = 1'b1;
    drive_start2(16'h0200, 16'd2);
    for (int cyc = 1; cyc <= 40 && done_c < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start2 = 1'b0;
      // a start pulse mid-run with different arguments must be ignored
      if (cyc == 2) begin start2 = 1'b1; base2 = 16'h0400; nf2 = 16'd7; end
      if (cyc == 3) start2 = 1'b0;
      if (en2) reads++;
      if (valid2 && ready2) begin
        if (v1 < 0) v1 = cyc; else v2 = cyc;
        g = {idx2, ap2, af2, dp2};
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL lat2_triplet: got %h want none", g); end
        else begin
          e = exp_q.pop_front();
          if (g !== e) begin n_err++; $display("FAIL lat2_triplet: got %h want %h", g, e); end
        end
      end
      if (done2) done_c = cyc;
    end
    n_vec++;
    if (v1 != 6 || v2 != 12 || done_c != 13 || reads != 6) begin
      n_err++;
      $display("FAIL lat2_timing: got hs %0d,%0d done %0d reads %0d want 6,12 done 13 reads 6",
               v1, v2, done_c, reads);
    end
  endtask

  task automatic test_reset_in_wait();
    int v1 = -1, done_c = -1;
    logic [111:0] e, g;
    ready1 = 1'b1;
    drive_start1(16'h0300, 16'd1);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start1 = 1'b0;
    end
    n_vec++;
    if (st1 !== ST_WAIT) begin n_err++; $display("FAIL rstwait_state: got %0d want %0d", st1, ST_WAIT); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({busy1, done1, en1, addr1, valid1, ap1, af1, dp1, idx1} !== '0 || st1 !== ST_IDLE) begin
      n_err++;
      $display("FAIL rstwait_outputs: got busy=%b en=%b valid=%b ap=%h af=%h dp=%h st=%0d want all 0",
               busy1, en1, valid1, ap1, af1, dp1, st1);
    end
    exp_q.delete();
    for (int i = 0; i < 3; i++) mem[16'h0310 + i] = $urandom;
    drive_start1(16'h0310, 16'd1);
    for (int cyc = 1; cyc <= 20 && done_c < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start1 = 1'b0;
      if (valid1 && ready1) begin
        v1 = cyc;
        g = {idx1, ap1, af1, dp1};
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rstwait_triplet: got %h want none", g); end
        else begin
          e = exp_q.pop_front();
          if (g !== e) begin n_err++; $display("FAIL rstwait_triplet: got %h want %h", g, e); end
        end
      end
      if (done1) done_c = cyc;
    end
    n_vec++;
    if (v1 != 5 || done_c != 6) begin
      n_err++; $display("FAIL rstwait_timing: got valid %0d done %0d want 5 done 6", v1, done_c);
    end
  endtask

  task automatic test_back_to_back();
    int done_c = -1, hs = 0;
    logic [111:0] e, g;
    drive_start1(16'($urandom), 16'd4);
    for (int cyc = 1; cyc <= 300 && done_c < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start1 = 1'b0;
      ready1 = 1'($urandom_range(0, 1));
      if (valid1 && ready1) begin
        hs++;
        g = {idx1, ap1, af1, dp1};
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_triplet: got %h want none", g); end
        else begin
          e = exp_q.pop_front();
          if (g !== e) begin n_err++; $display("FAIL b2b_triplet: got %h want %h", g, e); end
        end
      end
      if (done1) done_c = cyc;
    end
    n_vec++;
    if (done_c < 0 || hs != 4 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_complete: got done@%0d handshakes %0d left %0d want done, 4, 0",
               done_c, hs, exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_frames();
    test_wrap();
    test_lat2();
    test_reset_in_wait();
    test_back_to_back();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/feature_fetch_ctrl.md
# feature_fetch_ctrl

Sequencer that owns the feature BRAM read port and streams per-frame feature triplets (sigma_ap, sigma_af, sigma_dp) to the modulation classifier. On a start command it walks a contiguous frame table in BRAM, issues three reads per frame, and aligns the returned words to the BRAM read latency. It presents each triplet on a valid/ready handshake and signals completion. It replaces free-running address counting with an explicit, back-pressurable schedule.

## Interface
- ADDR_W, 16, BRAM address width
- DATA_W, 32, BRAM word / feature width
- BRAM_LAT, 1, BRAM read latency in cycles (legal: 1 or 2)
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- start  in  1  begin run; sampled only in IDLE
- base_addr  in  ADDR_W  address of word 0 of frame 0; latched on accepted start
- num_frames  in  16  frames to fetch; latched on accepted start
- busy  out  1  run in progress
- done  out  1  one-cycle completion pulse
- bram_en  out  1  BRAM read enable
- bram_addr  out  ADDR_W  BRAM read address
- bram_dout  in  DATA_W  BRAM read data
- feat_valid  out  1  triplet available
- feat_ready  in  1  classifier accepts triplet
- sigma_ap, sigma_af, sigma_dp  out  DATA_W each  feature triplet
- frame_idx  out  16  index of presented frame

## Operation
- States: IDLE, ISSUE, WAIT, PRESENT, DONE.
- IDLE: start=1 -> latch base_addr/num_frames, frame counter=0; go ISSUE, or DONE if num_frames=0 (no BRAM access).
- ISSUE: 3 cycles, bram_en=1, bram_addr = base + 3*frame + k, k=0,1,2; then WAIT.
- WAIT: until the third read's data is captured; then PRESENT.
- Capture: a BRAM_LAT-deep tag pipe (valid + k) follows each issued read; the word returning with tag k goes to sigma_ap (0), sigma_af (1), sigma_dp (2).
- PRESENT: feat_valid=1, triplet and frame_idx held stable until feat_ready=1. On handshake: if frame = num_frames-1 -> DONE, else frame+1 -> ISSUE.
- DONE: done=1 for one cycle, busy=0; -> IDLE.
- Address arithmetic modulo 2^ADDR_W; wrap past the top is legal and silent.
- start while not in IDLE is ignored; latched base_addr/num_frames are not affected by input changes mid-run.
- bram_en=0 outside ISSUE; write port not driven by this block (tied read-only).
- rst at any time: next cycle IDLE, tag pipe cleared, all outputs at reset values; an in-flight BRAM return is discarded.

## Timing
- Reset values: busy=0, done=0, bram_en=0, bram_addr=0, feat_valid=0, sigma_*=0, frame_idx=0.
- Cycle 0: start accepted in IDLE. Cycles 1-3: ISSUE, busy=1 from cycle 1.
- Read issued in cycle c returns on bram_dout in cycle c+BRAM_LAT, captured at that cycle's closing edge.
- First feat_valid in cycle 4+BRAM_LAT (cycle 5 for BRAM_LAT=1).
- Handshake in cycle h with feat_ready=1 -> next ISSUE starts h+1; frame period with ready held high = 4+BRAM_LAT cycles.
- Last handshake in cycle h -> done=1, busy=0 in h+1; IDLE in h+2; new start accepted from h+2.
- feat_ready ignored when feat_valid=0.
- num_frames=0: done in cycle 1, busy never rises.

## Structure
- Shared package modclass_pkg: FEATS_PER_FRAME=3, state enum, feature-slot indices (AP=0, AF=1, DP=2), mod_type codes (000 unknown, 001 AM, 010 FM, 011 PSK, 100 ASK, 101 FSK) for use by the classifier.
- One sub-module natural: feat_rd_tag_pipe (parameterised BRAM_LAT-deep valid+slot delay line).

## Test plan
- BRAM_LAT=1, base=0x0000, num_frames=2, words 80,120,150,5,10,400, ready high -> triplets (80,120,150) idx0 at cycle 5, (5,10,400) idx1 at cycle 10, done at cycle 11.
- Backpressure: feat_ready low for 7 cycles on frame 0 -> sigma_*/frame_idx stable, bram_en=0 throughout stall, no extra reads.
- num_frames=0 -> done pulse at cycle 1, no bram_en, busy stays 0.
- Wrap: base=0xFFFE, num_frames=1 -> addresses 0xFFFE,0xFFFF,0x0000; data mapped in that order.
- BRAM_LAT=2 -> first feat_valid at cycle 6; start pulsed mid-run ignored.
- rst asserted in WAIT -> next cycle all outputs zero, IDLE; fresh start yields correct frame 0 triplet, no stale data.
